core_dmem_router: RTL and testbench

- Parametrised successor to the single-region core data-bus MMIO mux.
- Routes the core data memory bus to one of NT memory-mapped IO targets or to the external memory port.
- Tracks up to DEPTH outstanding requests, so targets with variable response latency are supported.
- Returns responses to the core strictly in request order; sits between the core LSU and external/MMIO interconnect.

---
 rtl/core_dmem_router.sv | 179 +++++++++++++++++
 tb/tb_core_dmem_router.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_dmem_router.sv
// core_dmem_router: steers core data-bus requests to MMIO targets or external
// memory, tracking outstanding requests so responses return in request order.
module core_dmem_router #(
  parameter int NT = 2,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int DEPTH = 4,
  parameter logic [NT*ADDR_W-1:0] REGION_BASE = {64'h2000, 64'h1000},
  parameter logic [NT*ADDR_W-1:0] REGION_MASK = {64'h0FFF, 64'h0FFF},
  localparam int STRB_W = DATA_W / 8
) (
  input  logic                 g_clk,
  input  logic                 g_reset,
  input  logic                 int_req,
  input  logic [ADDR_W-1:0]    int_addr,
  input  logic                 int_wen,
  input  logic [STRB_W-1:0]    int_strb,
  input  logic [DATA_W-1:0]    int_wdata,
  output logic                 int_gnt,
  output logic                 int_rsp_valid,
  output logic                 int_err,
  output logic [DATA_W-1:0]    int_rdata,
  output logic                 ext_req,
  input  logic                 ext_gnt,
  output logic [ADDR_W-1:0]    ext_addr,
  output logic                 ext_wen,
  output logic [STRB_W-1:0]    ext_strb,
  output logic [DATA_W-1:0]    ext_wdata,
  input  logic                 ext_rsp_valid,
  output logic                 ext_rsp_ready,
  input  logic                 ext_err,
  input  logic [DATA_W-1:0]    ext_rdata,
  output logic [NT-1:0]        mmio_req,
  input  logic [NT-1:0]        mmio_gnt,
  output logic [ADDR_W-1:0]    mmio_addr,
  output logic                 mmio_wen,
  output logic [STRB_W-1:0]    mmio_strb,
  output logic [DATA_W-1:0]    mmio_wdata,
  input  logic [NT-1:0]        mmio_rsp_valid,
  output logic [NT-1:0]        mmio_rsp_ready,
  input  logic [NT-1:0]        mmio_err,
  input  logic [NT*DATA_W-1:0] mmio_rdata,
  output logic                 rsp_stray
);

  localparam int IDW = $clog2(NT + 1);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;

  logic [IDW-1:0] fifo_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q;
  logic [PW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           stray_q;

  logic [IDW-1:0] sel_id;
  logic [IDW-1:0] head_id;
  logic           sel_gnt;
  logic           full;
  logic           req_ok;
  logic           active;
  logic           push;
  logic           pop;
  logic [NT:0]    pend;
  logic [PW-1:0]  off;
  logic           stray_set;

  assign ext_addr   = int_addr;
  assign ext_wen    = int_wen;
  assign ext_strb   = int_strb;
  assign ext_wdata  = int_wdata;
  assign mmio_addr  = int_addr;
  assign mmio_wen   = int_wen;
  assign mmio_strb  = int_strb;
  assign mmio_wdata = int_wdata;

  // descending scan so the lowest hitting region wins
  always_comb begin
    sel_id = '0;
    for (int i = NT - 1; i >= 0; i--) begin
      if ((int_addr & ~REGION_MASK[i*ADDR_W +: ADDR_W]) ==
          (REGION_BASE[i*ADDR_W +: ADDR_W] &
           ~REGION_MASK[i*ADDR_W +: ADDR_W]))
        sel_id = IDW'(i + 1);
    end
  end

  assign full   = (count_q == CW'(DEPTH));
  assign req_ok = int_req && !full && !g_reset;

  always_comb begin
    ext_req  = 1'b0;
    mmio_req = '0;
    sel_gnt  = 1'b0;
    if (sel_id == '0) begin
      ext_req = req_ok;
      sel_gnt = ext_gnt;
    end
    for (int i = 0; i < NT; i++) begin
      if (sel_id == IDW'(i + 1)) begin
        mmio_req[i] = req_ok;
        sel_gnt     = mmio_gnt[i];
      end
    end
  end

  assign int_gnt = sel_gnt && !full && !g_reset;
  assign push    = int_req && int_gnt;

  assign head_id = fifo_q[rd_ptr_q];
  assign active  = (count_q != '0) && !g_reset;

  always_comb begin
    ext_rsp_ready  = 1'b0;
    mmio_rsp_ready = '0;
    int_rsp_valid  = 1'b0;
    int_err        = 1'b0;
    int_rdata      = '0;
    if (active) begin
      if (head_id == '0) begin
        ext_rsp_ready = 1'b1;
        int_rsp_valid = ext_rsp_valid;
        int_err       = ext_err;
        int_rdata     = ext_rdata;
      end
      for (int i = 0; i < NT; i++) begin
        if (head_id == IDW'(i + 1)) begin
          mmio_rsp_ready[i] = 1'b1;
          int_rsp_valid     = mmio_rsp_valid[i];
          int_err           = mmio_err[i];
          int_rdata         = mmio_rdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign pop = int_rsp_valid;

  // a target still owed a response is only back-pressured, not stray
  always_comb begin
    pend = '0;
    off  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      off = PW'(k) - rd_ptr_q;
      if ({1'b0, off} < count_q) begin
        for (int j = 0; j <= NT; j++) begin
          if (fifo_q[k] == IDW'(j))
            pend[j] = 1'b1;
        end
      end
    end
  end

  assign stray_set = |({mmio_rsp_valid, ext_rsp_valid} & ~pend);
  assign rsp_stray = stray_q;

  always_ff @(posedge g_clk) begin
    if (push)
      fifo_q[wr_ptr_q] <= sel_id;
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stray_q  <= 1'b0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
      if (stray_set)
        stray_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_core_dmem_router.sv
// tb_core_dmem_router: directed checks of routing, ordering, full-stall,
// stray detection and reset for core_dmem_router.
module tb_core_dmem_router;

  logic         g_clk = 1'b0;
  logic         g_reset;
  logic         int_req;
  logic [63:0]  int_addr;
  logic         int_wen;
  logic [7:0]   int_strb;
  logic [63:0]  int_wdata;
  logic         int_gnt;
  logic         int_rsp_valid;
  logic         int_err;
  logic [63:0]  int_rdata;
  logic         ext_req;
  logic         ext_gnt;
  logic [63:0]  ext_addr;
  logic         ext_wen;
  logic [7:0]   ext_strb;
  logic [63:0]  ext_wdata;
  logic         ext_rsp_valid;
  logic         ext_rsp_ready;
  logic         ext_err;
  logic [63:0]  ext_rdata;
  logic [1:0]   mmio_req;
  logic [1:0]   mmio_gnt;
  logic [63:0]  mmio_addr;
  logic         mmio_wen;
  logic [7:0]   mmio_strb;
  logic [63:0]  mmio_wdata;
  logic [1:0]   mmio_rsp_valid;
  logic [1:0]   mmio_rsp_ready;
  logic [1:0]   mmio_err;
  logic [127:0] mmio_rdata;
  logic         rsp_stray;

  int checks = 0;
  int errors = 0;

  core_dmem_router dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .int_req(int_req), .int_addr(int_addr), .int_wen(int_wen),
    .int_strb(int_strb), .int_wdata(int_wdata), .int_gnt(int_gnt),
    .int_rsp_valid(int_rsp_valid), .int_err(int_err),
    .int_rdata(int_rdata),
    .ext_req(ext_req), .ext_gnt(ext_gnt), .ext_addr(ext_addr),
    .ext_wen(ext_wen), .ext_strb(ext_strb), .ext_wdata(ext_wdata),
    .ext_rsp_valid(ext_rsp_valid), .ext_rsp_ready(ext_rsp_ready),
    .ext_err(ext_err), .ext_rdata(ext_rdata),
    .mmio_req(mmio_req), .mmio_gnt(mmio_gnt), .mmio_addr(mmio_addr),
    .mmio_wen(mmio_wen), .mmio_strb(mmio_strb),
    .mmio_wdata(mmio_wdata),
    .mmio_rsp_valid(mmio_rsp_valid), .mmio_rsp_ready(mmio_rsp_ready),
    .mmio_err(mmio_err), .mmio_rdata(mmio_rdata),
    .rsp_stray(rsp_stray)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge g_clk);
    #1;
  endtask

  task automatic idle();
    int_req        = 1'b0;
    int_addr       = '0;
    int_wen        = 1'b0;
    int_strb       = '0;
    int_wdata      = '0;
    ext_gnt        = 1'b0;
    ext_rsp_valid  = 1'b0;
    ext_err        = 1'b0;
    ext_rdata      = '0;
    mmio_gnt       = '0;
    mmio_rsp_valid = '0;
    mmio_err       = '0;
    mmio_rdata     = '0;
  endtask

  initial begin
    idle();
    g_reset = 1'b1;
    cyc();
    int_req  = 1'b1;
    int_addr = 64'h1008;
    mmio_gnt = 2'b11;
    #1;
    chk("rst_gnt", int_gnt, 0);
    chk("rst_mreq", mmio_req, 0);
    chk("rst_rvld", int_rsp_valid, 0);
    cyc();

    // read mmio0, response next cycle
    g_reset = 1'b0;
    #1;
    chk("t1_mreq", mmio_req, 2'b01);
    chk("t1_ereq", ext_req, 0);
    chk("t1_gnt", int_gnt, 1);
    chk("t1_rvld0", int_rsp_valid, 0);
    cyc();
    idle();
    mmio_rsp_valid = 2'b01;
    mmio_rdata     = 128'hAA;
    #1;
    chk("t1_rvld", int_rsp_valid, 1);
    chk("t1_rdata", int_rdata, 64'hAA);
    chk("t1_rrdy", mmio_rsp_ready, 2'b01);
    cyc();
    idle();
    #1;
    chk("t1_rvld_off", int_rsp_valid, 0);
    chk("t1_rrdy_off", mmio_rsp_ready, 0);

    // external write with error response
    int_req   = 1'b1;
    int_addr  = 64'h8000_0000;
    int_wen   = 1'b1;
    int_strb  = 8'hF0;
    int_wdata = 64'h1234_5678;
    ext_gnt   = 1'b1;
    mmio_gnt  = 2'b11;
    #1;
    chk("t2_ereq", ext_req, 1);
    chk("t2_mreq", mmio_req, 0);
    chk("t2_gnt", int_gnt, 1);
    chk("t2_ewen", ext_wen, 1);
    chk("t2_estrb", ext_strb, 8'hF0);
    chk("t2_mwdata", mmio_wdata, 64'h1234_5678);
    chk("t2_maddr", mmio_addr, 64'h8000_0000);
    cyc();
    idle();
    ext_rsp_valid = 1'b1;
    ext_err       = 1'b1;
    #1;
    chk("t2_rvld", int_rsp_valid, 1);
    chk("t2_err", int_err, 1);
    chk("t2_erdy", ext_rsp_ready, 1);
    cyc();
    idle();
    #1;
    chk("t2_empty_rdy", ext_rsp_ready, 0);
    chk("t2_empty_err", int_err, 0);

    // mmio1 slow, ext fast: ext must wait
    int_req  = 1'b1;
    int_addr = 64'h2010;
    mmio_gnt = 2'b10;
    #1;
    chk("t3_mreq", mmio_req, 2'b10);
    chk("t3_gnt1", int_gnt, 1);
    cyc();
    int_addr = 64'h9000;
    mmio_gnt = 2'b00;
    ext_gnt  = 1'b1;
    #1;
    chk("t3_ereq", ext_req, 1);
    chk("t3_gnt2", int_gnt, 1);
    cyc();
    idle();
    ext_rsp_valid = 1'b1;
    ext_rdata     = 64'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_hold_vld", int_rsp_valid, 0);
      chk("t3_hold_erdy", ext_rsp_ready, 0);
      cyc();
    end
    chk("t3_nostray", rsp_stray, 0);
    mmio_rsp_valid = 2'b10;
    mmio_rdata     = {64'h77, 64'h0};
    #1;
    chk("t3_m1_vld", int_rsp_valid, 1);
    chk("t3_m1_data", int_rdata, 64'h77);
    chk("t3_m1_rdy", mmio_rsp_ready, 2'b10);
    cyc();
    mmio_rsp_valid = 2'b00;
    #1;
    chk("t3_e_vld", int_rsp_valid, 1);
    chk("t3_e_data", int_rdata, 64'h55);
    chk("t3_e_rdy", ext_rsp_ready, 1);
    cyc();
    idle();
    #1;
    chk("t3_done_vld", int_rsp_valid, 0);
    chk("t3_stray", rsp_stray, 0);

    // fill four entries, fifth stalls even with a pop
    int_req  = 1'b1;
    int_addr = 64'h1000;
    mmio_gnt = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_fill_gnt", int_gnt, 1);
      cyc();
    end
    mmio_rsp_valid = 2'b01;
    mmio_rdata     = 128'h11;
    #1;
    chk("t4_full_gnt", int_gnt, 0);
    chk("t4_full_mreq", mmio_req, 0);
    chk("t4_full_pop", int_rsp_valid, 1);
    chk("t4_full_data", int_rdata, 64'h11);
    cyc();
    mmio_rsp_valid = 2'b00;
    #1;
    chk("t4_resume_gnt", int_gnt, 1);
    chk("t4_resume_mreq", mmio_req, 2'b01);
    cyc();
    int_req        = 1'b0;
    mmio_rsp_valid = 2'b01;
    #1;
    chk("t4_pop_vld", int_rsp_valid, 1);
    cyc();
    mmio_rsp_valid = 2'b00;
    #1;
    chk("t6_pre_rdy", mmio_rsp_ready, 2'b01);

    // reset with three outstanding
    g_reset        = 1'b1;
    int_req        = 1'b1;
    mmio_rsp_valid = 2'b01;
    #1;
    chk("t6_rst_gnt", int_gnt, 0);
    chk("t6_rst_mreq", mmio_req, 0);
    chk("t6_rst_vld", int_rsp_valid, 0);
    chk("t6_rst_rdy", mmio_rsp_ready, 0);
    cyc();
    g_reset        = 1'b0;
    int_req        = 1'b0;
    mmio_rsp_valid = 2'b00;
    #1;
    chk("t6_post_rdy", mmio_rsp_ready, 0);
    chk("t6_post_vld", int_rsp_valid, 0);
    chk("t6_post_stray", rsp_stray, 0);
    int_req  = 1'b1;
    int_addr = 64'h1008;
    #1;
    chk("t6_new_gnt", int_gnt, 1);
    cyc();
    int_req        = 1'b0;
    mmio_rsp_valid = 2'b01;
    mmio_rdata     = 128'h3C;
    #1;
    chk("t6_new_vld", int_rsp_valid, 1);
    chk("t6_new_data", int_rdata, 64'h3C);
    cyc();
    idle();

    // response with nothing outstanding
    mmio_rsp_valid = 2'b01;
    #1;
    chk("t5_vld", int_rsp_valid, 0);
    chk("t5_rdy", mmio_rsp_ready, 0);
    chk("t5_stray_pre", rsp_stray, 0);
    cyc();
    mmio_rsp_valid = 2'b00;
    #1;
    chk("t5_stray_set", rsp_stray, 1);
    cyc();
    cyc();
    chk("t5_stray_hold", rsp_stray, 1);
    g_reset = 1'b1;
    cyc();
    g_reset = 1'b0;
    #1;
    chk("t5_stray_clr", rsp_stray, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
